// File: rtl/mm_bram_ctrl.sv
// BRAM port-B master for the Montgomery multiplier demo: loads the FIOS operands, runs the core, stores the result.
// Optional FIOS cycle counter (extra port and extra result word) enabled by defining MM_BRAM_CTRL_CYCLE_COUNT_EN.
module mm_bram_ctrl #(
    parameter int  WIDTH        = 256,
    parameter int  READ_LATENCY = 1,
    localparam int S            = (WIDTH + 1) / 17 + 1
) (
    input  logic            clock_i,
    input  logic            reset_n_i,
    input  logic            start_i,
    output logic            done_o,
    output logic            busy_o,
    output logic            bram_en_o,
    output logic [3:0]      bram_we_o,
    output logic [31:0]     bram_addr_o,
    output logic [31:0]     bram_din_o,
    input  logic [31:0]     bram_dout_i,
    output logic [16:0]     p_prime_0_o,
    output logic [S*17-1:0] p_o,
    output logic [S*17-1:0] a_o,
    output logic [S*17-1:0] b_o,
    output logic            fios_start_o,
    input  logic            fios_done_i,
    input  logic [S*17-1:0] res_i
`ifdef MM_BRAM_CTRL_CYCLE_COUNT_EN
    ,
    output logic [31:0]     fios_cycles_o
`endif
);

    localparam int KW = $clog2(3 * S + 2);
    localparam int JW = $clog2(S + 2);
`ifdef MM_BRAM_CTRL_CYCLE_COUNT_EN
    localparam int J_END = S;
`else
    localparam int J_END = S - 1;
`endif
    localparam logic [KW-1:0] K_LAST = KW'(3 * S);
    localparam logic [JW-1:0] J_LAST = JW'(J_END);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] LOAD  = 3'd1;
    localparam logic [2:0] DRAIN = 3'd2;
    localparam logic [2:0] START = 3'd3;
    localparam logic [2:0] WAIT  = 3'd4;
    localparam logic [2:0] STORE = 3'd5;
    localparam logic [2:0] DONE  = 3'd6;

    logic [2:0]        state;
    logic [KW-1:0]     k;
    logic [JW-1:0]     j;
    logic [1:0]        drain_cnt;
    logic [S*17-1:0]   res_q;
    logic [16:0]       res_limb;

    logic [READ_LATENCY-1:0] vld_pipe;
    logic [KW-1:0]           k_pipe [READ_LATENCY];
    logic [KW-1:0]           cap_k;
    logic [16:0]             cap_word;

    logic unused_dout_hi;
    assign unused_dout_hi = ^bram_dout_i[31:17];

`ifdef MM_BRAM_CTRL_CYCLE_COUNT_EN
    logic [31:0] cyc_q;
    assign fios_cycles_o = cyc_q;
`endif

    // Control outputs decode directly from the state register, so reset forces them idle at once.
    assign busy_o       = (state != IDLE) && (state != DONE);
    assign done_o       = (state == DONE);
    assign fios_start_o = (state == START);
    assign bram_en_o    = (state == LOAD) || (state == STORE);
    assign bram_we_o    = (state == STORE) ? 4'hF : 4'h0;

    // NOTE: every output of this block is assigned a default first, otherwise unlisted states infer latches.
    always_comb begin
        bram_addr_o = '0;
        bram_din_o  = '0;
        res_limb    = '0;
        for (int i = 0; i < S; i++) begin
            if (j == JW'(i)) res_limb = res_q[17*i +: 17];
        end
        case (state)
            LOAD: bram_addr_o = 32'(k) << 2;
            STORE: begin
`ifdef MM_BRAM_CTRL_CYCLE_COUNT_EN
                if (j == JW'(S)) begin
                    bram_addr_o = 32'(3 * S + 1) << 2;
                    bram_din_o  = cyc_q;
                end else
`endif
                begin
                    bram_addr_o = 32'(j) << 2;
                    bram_din_o  = {15'b0, res_limb};
                end
            end
            default: ;
        endcase
    end

    // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state     <= IDLE;
            k         <= '0;
            j         <= '0;
            drain_cnt <= '0;
            res_q     <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start_i) begin
                        state <= LOAD;
                        k     <= '0;
                    end
                end
                LOAD: begin
                    if (k == K_LAST) begin
                        state     <= DRAIN;
                        drain_cnt <= '0;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                DRAIN: begin
                    if (drain_cnt == 2'(READ_LATENCY - 1)) state <= START;
                    else drain_cnt <= drain_cnt + 1'b1;
                end
                START: state <= WAIT;
                WAIT: begin
                    if (fios_done_i) begin
                        res_q <= res_i;
                        j     <= '0;
                        state <= STORE;
                    end
                end
                STORE: begin
                    if (j == J_LAST) state <= DONE;
                    else j <= j + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign cap_k    = k_pipe[READ_LATENCY-1];
    assign cap_word = bram_dout_i[16:0];

    // Read data for the address issued in cycle t lands READ_LATENCY cycles later; k travels alongside it.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            vld_pipe    <= '0;
            // NOTE: this tiny delay line is reset like ordinary flops; a real RAM array would not be.
            for (int i = 0; i < READ_LATENCY; i++) k_pipe[i] <= '0;
            p_prime_0_o <= '0;
            p_o         <= '0;
            a_o         <= '0;
            b_o         <= '0;
        end else begin
            vld_pipe[0] <= (state == LOAD);
            k_pipe[0]   <= k;
            for (int i = 1; i < READ_LATENCY; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                k_pipe[i]   <= k_pipe[i-1];
            end
            if (vld_pipe[READ_LATENCY-1]) begin
                if (cap_k == '0) p_prime_0_o <= cap_word;
                for (int i = 0; i < S; i++) begin
                    if (cap_k == KW'(i + 1))         p_o[17*i +: 17] <= cap_word;
                    if (cap_k == KW'(S + 1 + i))     a_o[17*i +: 17] <= cap_word;
                    if (cap_k == KW'(2 * S + 1 + i)) b_o[17*i +: 17] <= cap_word;
                end
            end
        end
    end

`ifdef MM_BRAM_CTRL_CYCLE_COUNT_EN
    // Counts WAIT cycles spent before the core reports done; freezes on done and saturates.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cyc_q <= '0;
        end else if (state == START) begin
            cyc_q <= '0;
        end else if (state == WAIT && !fios_done_i && cyc_q != 32'hFFFF_FFFF) begin
            cyc_q <= cyc_q + 1'b1;
        end
    end
`endif

endmodule
